rst_ce_sequencer: RTL and testbench



---
 rtl/rst_ce_sequencer.sv | 149 ++++++++++++++
 tb/tb_rst_ce_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rst_ce_sequencer.sv
// Block reset / clock-enable sequencer: holds rst_out after a reset request,
// waits a gap, then runs a (optionally divided) clock enable until the next request.
module rst_ce_sequencer #(
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned CE_DELAY = 2,
  parameter int unsigned CE_DIV   = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             pause,
  output logic             rst_out,
  output logic             ce,
  output logic             ready,
  output logic [CNT_W-1:0] seq_count
);

  localparam int unsigned MAX_A = (RST_HOLD > CE_DELAY) ? RST_HOLD : CE_DELAY;
  localparam int unsigned MAX_V = (MAX_A > CE_DIV) ? MAX_A : CE_DIV;
  localparam int unsigned CW    = (MAX_V < 1) ? 1 : $clog2(MAX_V + 1);

  localparam logic [CW-1:0]    HOLD_LOAD = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0]    GAP_LOAD  = CW'(CE_DELAY - 1);
  localparam logic [CW-1:0]    DIV_LAST  = CW'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] SEQ_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HOLD  = 2'd1,
    S_GAP   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    div, div_nxt;
  logic [CW-1:0]    div_adv;
  logic             rst_out_nxt, ce_nxt, ready_nxt;
  logic [CNT_W-1:0] seq_nxt;
  logic             req;

  assign req = rst | soft_rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (req) begin
      state_nxt = S_RESET;
    end else begin
      unique case (state)
        S_RESET: state_nxt = S_HOLD;
        S_HOLD:  if (cnt == '0) state_nxt = S_GAP;
        S_GAP:   if (cnt == '0) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_RESET;
      endcase
    end
  end

  // Output and counter next values; every output is the flop of one of these
  always_comb begin
    cnt_nxt     = cnt;
    div_nxt     = div;
    rst_out_nxt = rst_out;
    ce_nxt      = ce;
    ready_nxt   = ready;
    seq_nxt     = seq_count;
    div_adv     = (div == DIV_LAST) ? '0 : CW'(div + CW'(1));
    if (req) begin
      cnt_nxt     = '0;
      div_nxt     = '0;
      rst_out_nxt = 1'b1;
      ce_nxt      = 1'b0;
      ready_nxt   = 1'b0;
      if (rst) seq_nxt = '0;
    end else begin
      unique case (state)
        S_RESET: begin
          cnt_nxt     = HOLD_LOAD;
          rst_out_nxt = 1'b1;
          ce_nxt      = 1'b0;
          ready_nxt   = 1'b0;
        end
        S_HOLD: begin
          if (cnt == '0) begin
            rst_out_nxt = 1'b0;
            cnt_nxt     = GAP_LOAD;
          end else begin
            cnt_nxt = CW'(cnt - CW'(1));
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            ce_nxt    = 1'b1;
            ready_nxt = 1'b1;
            div_nxt   = '0;
            if (seq_count != SEQ_MAX) seq_nxt = CNT_W'(seq_count + CNT_W'(1));
          end else begin
            cnt_nxt = CW'(cnt - CW'(1));
          end
        end
        S_RUN: begin
          // A paused cycle freezes the divider so the enable phase resumes intact
          if (pause) begin
            ce_nxt = 1'b0;
          end else begin
            div_nxt = div_adv;
            ce_nxt  = (div_adv == '0);
          end
        end
        default: begin
          rst_out_nxt = 1'b1;
          ce_nxt      = 1'b0;
          ready_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div       <= '0;
      rst_out   <= 1'b1;
      ce        <= 1'b0;
      ready     <= 1'b0;
      seq_count <= '0;
    end else begin
      cnt       <= cnt_nxt;
      div       <= div_nxt;
      rst_out   <= rst_out_nxt;
      ce        <= ce_nxt;
      ready     <= ready_nxt;
      seq_count <= seq_nxt;
    end
  end

endmodule

// File: tb/tb_rst_ce_sequencer.sv
// Randomised and directed bench for rst_ce_sequencer: two instances (CE_DIV=1 and 3)
// share stimulus and are compared each cycle against a timeline-based reference model.
module tb_rst_ce_sequencer;

  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned CE_DELAY = 2;
  localparam int unsigned CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst, soft_rst, pause;
  logic             rst_out1, ce1, ready1;
  logic             rst_out3, ce3, ready3;
  logic [CNT_W-1:0] seq1, seq3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time since release, count of unpaused RUN edges
  int m_t       = -1;
  int m_n       = 0;
  bit m_running = 1'b0;
  int m_seq     = 0;
  bit e_rst_out = 1'b1;
  bit e_ce1     = 1'b0;
  bit e_ce3     = 1'b0;
  bit e_ready   = 1'b0;

  always #5 clk = ~clk;

  rst_ce_sequencer #(.RST_HOLD(RST_HOLD), .CE_DELAY(CE_DELAY), .CE_DIV(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .pause(pause),
    .rst_out(rst_out1), .ce(ce1), .ready(ready1), .seq_count(seq1)
  );

  rst_ce_sequencer #(.RST_HOLD(RST_HOLD), .CE_DELAY(CE_DELAY), .CE_DIV(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .pause(pause),
    .rst_out(rst_out3), .ce(ce3), .ready(ready3), .seq_count(seq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p);
    if (r || s) begin
      m_t = -1; m_running = 1'b0;
      e_rst_out = 1'b1; e_ce1 = 1'b0; e_ce3 = 1'b0; e_ready = 1'b0;
      if (r) m_seq = 0;
    end else if (!m_running) begin
      m_t++;
      e_rst_out = (m_t < int'(RST_HOLD));
      e_ce1 = 1'b0; e_ce3 = 1'b0; e_ready = 1'b0;
      if (m_t == int'(RST_HOLD + CE_DELAY)) begin
        m_running = 1'b1; m_n = 0;
        e_ce1 = 1'b1; e_ce3 = 1'b1; e_ready = 1'b1;
        if (m_seq < 255) m_seq++;
      end
    end else begin
      if (p) begin
        e_ce1 = 1'b0; e_ce3 = 1'b0;
      end else begin
        m_n++;
        e_ce1 = 1'b1;
        e_ce3 = ((m_n % 3) == 0);
      end
    end
  endtask

  task automatic tick(input bit r, input bit s, input bit p);
    rst = r; soft_rst = s; pause = p;
    @(posedge clk);
    model_edge(r, s, p);
    #1;
    check("rst_out1", 32'(rst_out1), 32'(e_rst_out));
    check("rst_out3", 32'(rst_out3), 32'(e_rst_out));
    check("ce1", 32'(ce1), 32'(e_ce1));
    check("ce3", 32'(ce3), 32'(e_ce3));
    check("ready1", 32'(ready1), 32'(e_ready));
    check("ready3", 32'(ready3), 32'(e_ready));
    check("seq1", 32'(seq1), 32'(m_seq));
    check("seq3", 32'(seq3), 32'(m_seq));
    check("inv1", 32'(rst_out1 & ce1), 32'd0);
    check("inv3", 32'(rst_out3 & ce3), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; soft_rst = 1'b0; pause = 1'b0;
    // Power-on reset and first startup
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    idle(20);
    // Pause in RUN, including phase freeze for the divided instance
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
    idle(4);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    idle(7);
    // Soft reset keeps the startup count, hard reset clears it
    tick(1'b0, 1'b1, 1'b0);
    idle(12);
    tick(1'b1, 1'b0, 1'b0);
    idle(12);
    // Reset during HOLD, then during GAP
    tick(1'b0, 1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b0, 1'b0);
    idle(5);
    tick(1'b0, 1'b1, 1'b0);
    idle(12);
    check("seq_after_restarts", 32'(seq1), 32'd1);
    // Random traffic
    for (int i = 0; i < 2000; i++)
      tick(($urandom % 64) == 0, ($urandom % 24) == 0, ($urandom % 4) == 0);
    // Drive the startup counter into saturation
    for (int i = 0; i < 262; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      idle(7);
    end
    check("seq_saturated", 32'(seq1), 32'd255);
    check("seq_saturated3", 32'(seq3), 32'd255);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
